// File: rtl/alu_pkg.sv
// Shared opcodes, FSM state encoding and the reference ALU function
// used by the 4-bit ALU operand/opcode initiator.
package alu_pkg;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_DIV = 3'b011;
  localparam logic [2:0] OP_OR  = 3'b100;
  localparam logic [2:0] OP_MUL = 3'b101;

  localparam int CMD_W = 11;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_WAIT = 2'd1;
  localparam state_t ST_RESP = 2'd2;

  function automatic logic [7:0] alu_golden(
    input logic [2:0] op,
    input logic [3:0] a,
    input logic [3:0] b
  );
    logic [7:0] ea;
    logic [7:0] eb;
    logic [7:0] res;
    ea  = {4'h0, a};
    eb  = {4'h0, b};
    res = 8'h00;
    case (op)
      OP_ADD: res = ea + eb;
      OP_SUB: res = ea - eb;
      OP_AND: res = ea & eb;
      OP_DIV: res = (b == 4'h0) ? 8'h00 : ea / eb;
      OP_OR:  res = ea | eb;
      OP_MUL: res = ea * eb;
      default: res = 8'h00;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/alu_cmd_fifo.sv
// Synchronous command FIFO; pointers carry one extra wrap bit so
// full and empty are told apart without a separate counter.
module alu_cmd_fifo
  import alu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = CMD_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_push,
  input  logic         i_pop,
  input  logic [W-1:0] i_data,
  output logic [W-1:0] o_data,
  output logic         o_full,
  output logic         o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]  r_wr;
  logic [AW:0]  r_rd;
  logic [W-1:0] r_mem [DEPTH];
  logic         w_push;
  logic         w_pop;

  assign o_empty = (r_wr == r_rd);
  assign o_full  = (r_wr[AW] != r_rd[AW]) &&
                   (r_wr[AW-1:0] == r_rd[AW-1:0]);

  // A full FIFO refuses a push even when a pop frees a slot this edge.
  assign w_push = i_push & ~o_full;
  assign w_pop  = i_pop  & ~o_empty;
  assign o_data = r_mem[r_rd[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr <= '0;
      r_rd <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_pop)  r_rd <= r_rd + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr[AW-1:0]] <= i_data;
  end

endmodule

// File: rtl/alu_op_initiator.sv
// Drives queued {op,a,b} commands onto the ALU and returns results.
// Optional golden-model checker enabled with `define ALU_CHECK_EN.
module alu_op_initiator
  import alu_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int ALU_LAT = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [2:0] cmd_op,
  input  logic [3:0] cmd_a,
  input  logic [3:0] cmd_b,
  output logic [3:0] alu_a,
  output logic [3:0] alu_b,
  output logic [2:0] alu_op,
  input  logic [7:0] alu_result,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] rsp_data,
  output logic [2:0] rsp_op,
  output logic       rsp_err
);

  localparam int CW = $clog2(ALU_LAT + 2);
  localparam logic [CW-1:0] LOAD = CW'(ALU_LAT + 1);
  localparam logic [CW-1:0] ONE  = CW'(1);

  state_t          r_state;
  logic [CW-1:0]   r_cnt;
  logic [3:0]      r_alu_a;
  logic [3:0]      r_alu_b;
  logic [2:0]      r_alu_op;
  logic [7:0]      r_rsp_data;
  logic [2:0]      r_rsp_op;

  logic [CMD_W-1:0] w_head;
  logic             w_full;
  logic             w_empty;
  logic             w_pop;
  logic             w_capture;
  logic [2:0]       w_head_op;
  logic [3:0]       w_head_a;
  logic [3:0]       w_head_b;

  alu_cmd_fifo #(
    .DEPTH (DEPTH),
    .W     (CMD_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (cmd_valid),
    .i_pop   (w_pop),
    .i_data  ({cmd_op, cmd_a, cmd_b}),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign w_head_op = w_head[10:8];
  assign w_head_a  = w_head[7:4];
  assign w_head_b  = w_head[3:0];

  assign w_pop = ~w_empty &
                 ((r_state == ST_IDLE) |
                  ((r_state == ST_RESP) & rsp_ready));

  assign w_capture = (r_state == ST_WAIT) && (r_cnt == ONE);

  assign cmd_ready = ~w_full;
  assign rsp_valid = (r_state == ST_RESP);
  assign alu_a     = r_alu_a;
  assign alu_b     = r_alu_b;
  assign alu_op    = r_alu_op;
  assign rsp_data  = r_rsp_data;
  assign rsp_op    = r_rsp_op;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_alu_a    <= '0;
      r_alu_b    <= '0;
      r_alu_op   <= '0;
      r_rsp_data <= '0;
      r_rsp_op   <= '0;
    end else begin
      if (w_pop) begin
        r_alu_a  <= w_head_a;
        r_alu_b  <= w_head_b;
        r_alu_op <= w_head_op;
        r_cnt    <= LOAD;
        r_state  <= ST_WAIT;
      end
      unique case (r_state)
        ST_WAIT: begin
          r_cnt <= r_cnt - ONE;
          if (w_capture) begin
            r_rsp_data <= alu_result;
            r_rsp_op   <= r_alu_op;
            r_state    <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (rsp_ready && w_empty) r_state <= ST_IDLE;
        end
        default: ;
      endcase
    end
  end

`ifdef ALU_CHECK_EN
  logic [7:0] r_expected;
  logic       r_skip;
  logic       r_err;

  // Divide by zero has no defined result, so it is never flagged.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_expected <= '0;
      r_skip     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      if (w_pop) begin
        r_expected <= alu_golden(w_head_op, w_head_a, w_head_b);
        r_skip     <= (w_head_op == OP_DIV) && (w_head_b == 4'h0);
      end
      if (w_capture) r_err <= ~r_skip & (alu_result != r_expected);
    end
  end

  assign rsp_err = r_err;
`else
  assign rsp_err = 1'b0;
`endif

endmodule
